// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_queue
// Brief    : FIFO write buffer in front of the register file write port, with
//            in-flight hazard detection and youngest-value bypass.
// Revision : 1.0
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [ADDR_W-1:0]            InRegister,
    input  logic [DATA_W-1:0]            InData,
    input  logic                         WbEnable,
    output logic                         RegWrite,
    output logic [ADDR_W-1:0]            WriteRegister,
    output logic [DATA_W-1:0]            WriteData,
    input  logic [ADDR_W-1:0]            ReadRegister1,
    input  logic [ADDR_W-1:0]            ReadRegister2,
    output logic                         Hazard1,
    output logic                         Hazard2,
    output logic [DATA_W-1:0]            BypassData1,
    output logic [DATA_W-1:0]            BypassData2,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_reg_write;
    logic [ADDR_W-1:0]  r_write_register;
    logic [DATA_W-1:0]  r_write_data;

    logic w_ready;
    logic w_push;
    logic w_pop;

    assign w_ready = (r_count != c_full);
    // Writes to r0 finish the handshake but are dropped before the FIFO.
    assign w_push  = InValid && w_ready && (InRegister != '0);
    assign w_pop   = WbEnable && (r_count != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else begin
            r_reg_write <= w_pop;
            if (w_pop) begin
                r_write_register <= r_addr[r_head];
                r_write_data     <= r_data[r_head];
                r_head           <= r_head + 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: validity is tracked entirely by head/count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_addr[r_tail] <= InRegister;
            r_data[r_tail] <= InData;
        end
    end

    // Scan oldest to youngest so the last hit wins; the output stage is oldest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0]    hit;
        logic [c_ptr_w-1:0] idx;
        hit = '0;
        idx = '0;
        if (a != '0) begin
            if (r_reg_write && (r_write_register == a)) begin
                hit = {1'b1, r_write_data};
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = r_head + c_ptr_w'(k);
                if ((c_cnt_w'(k) < r_count) && (r_addr[idx] == a)) begin
                    hit = {1'b1, r_data[idx]};
                end
            end
        end
        return hit;
    endfunction

    logic [DATA_W:0] w_hit1;
    logic [DATA_W:0] w_hit2;

    always_comb begin
        w_hit1 = lookup(ReadRegister1);
        w_hit2 = lookup(ReadRegister2);
    end

    assign Hazard1       = w_hit1[DATA_W];
    assign BypassData1   = w_hit1[DATA_W-1:0];
    assign Hazard2       = w_hit2[DATA_W];
    assign BypassData2   = w_hit2[DATA_W-1:0];
    assign InReady       = w_ready;
    assign RegWrite      = r_reg_write;
    assign WriteRegister = r_write_register;
    assign WriteData     = r_write_data;
    assign Count         = r_count;

endmodule
`default_nettype wire
